// File: rtl/adder_pipe_if.sv
// adder_pipe_if -- operand/result handshake bundle for adder_pipe.
//   Request side : in_valid, in_ready, a, b, cin, sub
//   Response side: out_valid, out_ready, sum, carry, ovf
//   master = producer of operands / consumer of results (the environment)
//   slave  = the adder pipeline itself
interface adder_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, carry, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, carry, ovf
  );
endinterface

// File: rtl/adder_pipe.sv
// adder_pipe -- carry-chained pipelined adder/subtractor.
//   WIDTH-bit operands are added CHUNK bits per stage (STAGES = WIDTH/CHUNK,
//   WIDTH must be a multiple of CHUNK). Latency is STAGES cycles, one result
//   per cycle, with a global stall: every register holds when the output is
//   valid and not taken.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset (clears valids and result outputs)
//   bus   - adder_pipe_if.slave: operands a/b/cin/sub with in_valid/in_ready,
//           results sum/carry/ovf with out_valid/out_ready
module adder_pipe #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  adder_pipe_if.slave bus
);
  localparam int STAGES = WIDTH / CHUNK;

  logic advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    // Operand bits not yet consumed when entering stage k; the low CHUNK of
    // them are this stage's slice, the rest ride along to later stages.
    localparam int RW = WIDTH - k * CHUNK;

    logic [RW-1:0]          a_in, b_in;
    logic                   c_in, v_in;
    logic [CHUNK:0]         add;
    logic [(k+1)*CHUNK-1:0] s_n, s_q;
    logic                   c_q, v_q;

    if (k == 0) begin : g_first
      // Subtract as A + ~B + (cin ^ sub): borrow-in becomes a missing +1.
      assign a_in = bus.a;
      assign b_in = bus.sub ? ~bus.b : bus.b;
      assign c_in = bus.cin ^ bus.sub;
      assign v_in = bus.in_valid;
      assign s_n  = add[CHUNK-1:0];
    end else begin : g_next
      assign a_in = g_stg[k-1].g_fwd.a_q;
      assign b_in = g_stg[k-1].g_fwd.b_q;
      assign c_in = g_stg[k-1].c_q;
      assign v_in = g_stg[k-1].v_q;
      assign s_n  = {add[CHUNK-1:0], g_stg[k-1].s_q};
    end

    assign add = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]}
               + {{CHUNK{1'b0}}, c_in};

    // Data only loads with a valid slot so bubbles leave the last result
    // visible at the output.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (advance) begin
        v_q <= v_in;
        if (v_in) begin
          c_q <= add[CHUNK];
          s_q <= s_n;
        end
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [RW-CHUNK-1:0] a_q, b_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance && v_in) begin
          a_q <= a_in[RW-1:CHUNK];
          b_q <= b_in[RW-1:CHUNK];
        end
      end
    end else begin : g_last
      // Carry into the MSB is recovered as sum ^ a ^ b' at that bit.
      logic ovf_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          ovf_q <= 1'b0;
        else if (advance && v_in)
          ovf_q <= add[CHUNK] ^ add[CHUNK-1] ^ a_in[CHUNK-1] ^ b_in[CHUNK-1];
      end
    end
  end

  assign advance       = bus.out_ready || !g_stg[STAGES-1].v_q;
  assign bus.in_ready  = advance;
  assign bus.out_valid = g_stg[STAGES-1].v_q;
  assign bus.sum       = g_stg[STAGES-1].s_q;
  assign bus.carry     = g_stg[STAGES-1].c_q;
  assign bus.ovf       = g_stg[STAGES-1].g_last.ovf_q;
endmodule

// File: tb/tb_adder_pipe.sv
module tb_adder_pipe;
  localparam int S = 4;

  typedef struct packed {
    logic [15:0] sum;
    logic        carry;
    logic        ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  int   ncmp = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  adder_pipe_if #(.WIDTH(16)) bus16 ();
  adder_pipe_if #(.WIDTH(4))  bus4 ();

  adder_pipe #(.WIDTH(16), .CHUNK(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  adder_pipe #(.WIDTH(4),  .CHUNK(4)) dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));

  // Reference: plain integer arithmetic on the operands.
  function automatic res_t ref_op(int w, longint a, longint b, bit cin, bit sub);
    longint m, h, c, r, sa, sb, sr;
    res_t x;
    m = longint'(1) << w;
    h = m >> 1;
    c = cin;
    r = sub ? a - b - c : a + b + c;
    x.sum   = 16'(((r % m) + m) % m);
    x.carry = sub ? (a >= b + c) : (r >= m);
    sa = (a >= h) ? a - m : a;
    sb = (b >= h) ? b - m : b;
    sr = sub ? sa - sb - c : sa + sb + c;
    x.ovf = (sr >= h) || (sr < -h);
    return x;
  endfunction

  // Timing model of the 16-bit block: S slots that shift when the output is
  // empty or being taken; 'held' is the last result that reached the output.
  bit   sv[S];
  res_t sr[S];
  res_t held;

  task automatic model_clear();
    for (int i = 0; i < S; i++) begin sv[i] = 1'b0; sr[i] = '0; end
    held = '0;
  endtask

  task automatic tick();
    bit adv;
    adv = bus16.out_ready || !sv[S-1];
    @(posedge clk);
    if (adv) begin
      for (int i = S - 1; i > 0; i--) begin sv[i] = sv[i-1]; sr[i] = sr[i-1]; end
      sv[0] = bus16.in_valid;
      sr[0] = ref_op(16, bus16.a, bus16.b, bus16.cin, bus16.sub);
      if (sv[S-1]) held = sr[S-1];
    end
    #1;
  endtask

  task automatic drive16(bit iv, logic [15:0] a, logic [15:0] b, bit cin, bit sub, bit ordy);
    bus16.in_valid  = iv;
    bus16.a         = a;
    bus16.b         = b;
    bus16.cin       = cin;
    bus16.sub       = sub;
    bus16.out_ready = ordy;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    drive16(0, 16'h0, 16'h0, 0, 0, 1);
    bus4.in_valid = 0; bus4.a = '0; bus4.b = '0; bus4.cin = 0; bus4.sub = 0; bus4.out_ready = 1;
    model_clear();
    #1 rst_n = 1'b0;
    #2;
    ncmp++; if (bus16.out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b want 0", bus16.out_valid); end
    ncmp++; if ({bus16.sum, bus16.carry, bus16.ovf} !== 18'h0) begin nerr++; $display("FAIL reset_result: got %h/%b/%b want 0/0/0", bus16.sum, bus16.carry, bus16.ovf); end
    ncmp++; if (bus16.in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready: got %b want 1", bus16.in_ready); end
    ncmp++; if (bus4.out_valid !== 1'b0 || bus4.sum !== 4'h0) begin nerr++; $display("FAIL reset_w4: got v=%b s=%h want 0/0", bus4.out_valid, bus4.sum); end
    #5 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic [15:0] tv_a[6]    = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h0005, 16'h8000, 16'hFFFF};
    logic [15:0] tv_b[6]    = '{16'h0002, 16'h0001, 16'h0007, 16'h0007, 16'h0001, 16'hFFFF};
    bit          tv_cin[6]  = '{0, 0, 0, 1, 0, 1};
    bit          tv_sub[6]  = '{0, 0, 1, 1, 1, 0};
    logic [15:0] tv_sum[6]  = '{16'h0001, 16'h8000, 16'hFFFE, 16'hFFFD, 16'h7FFF, 16'hFFFF};
    bit          tv_c[6]    = '{1, 0, 0, 0, 1, 1};
    bit          tv_o[6]    = '{0, 1, 0, 0, 1, 0};
    for (int t = 0; t < 6; t++) begin
      drive16(1, tv_a[t], tv_b[t], tv_cin[t], tv_sub[t], 1);
      for (int c = 1; c <= S; c++) begin
        tick();
        bus16.in_valid = 0;
        ncmp++; if (bus16.out_valid !== (c == S)) begin nerr++; $display("FAIL latency[%0d] cyc %0d: got out_valid %b want %b", t, c, bus16.out_valid, c == S); end
      end
      ncmp++;
      if (bus16.sum !== tv_sum[t] || bus16.carry !== tv_c[t] || bus16.ovf !== tv_o[t]) begin
        nerr++;
        $display("FAIL directed[%0d]: got %h/%b/%b want %h/%b/%b", t, bus16.sum, bus16.carry, bus16.ovf, tv_sum[t], tv_c[t], tv_o[t]);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int ncons = 0;
    res_t snap;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (cyc < 4)      drive16(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1);
      else if (cyc < 7) drive16(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 0);
      else              drive16(0, 16'h0, 16'h0, 0, 0, 1);
      #1;
      ncmp++; if (bus16.in_ready !== (bus16.out_ready || !sv[S-1])) begin nerr++; $display("FAIL b2b_in_ready cyc %0d: got %b want %b", cyc, bus16.in_ready, bus16.out_ready || !sv[S-1]); end
      ncmp++; if (bus16.out_valid !== sv[S-1]) begin nerr++; $display("FAIL b2b_out_valid cyc %0d: got %b want %b", cyc, bus16.out_valid, sv[S-1]); end
      ncmp++; if ({bus16.sum, bus16.carry, bus16.ovf} !== held) begin nerr++; $display("FAIL b2b_result cyc %0d: got %h want %h", cyc, {bus16.sum, bus16.carry, bus16.ovf}, held); end
      if (cyc == 4) snap = {bus16.sum, bus16.carry, bus16.ovf};
      if (cyc >= 5 && cyc < 7) begin
        ncmp++; if ({bus16.sum, bus16.carry, bus16.ovf} !== snap) begin nerr++; $display("FAIL stall_stable cyc %0d: got %h want %h", cyc, {bus16.sum, bus16.carry, bus16.ovf}, snap); end
      end
      if (bus16.out_valid && bus16.out_ready) ncons++;
      tick();
    end
    ncmp++; if (ncons != 4) begin nerr++; $display("FAIL b2b_count: got %0d results want 4", ncons); end
  endtask

  task automatic test_random();
    logic [15:0] pick[4] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
    logic [15:0] a, b;
    for (int cyc = 0; cyc < 300; cyc++) begin
      a = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : 16'($urandom);
      drive16($urandom_range(0, 3) != 0, a, b, 1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
      #1;
      ncmp++; if (bus16.in_ready !== (bus16.out_ready || !sv[S-1])) begin nerr++; $display("FAIL rnd_in_ready cyc %0d: got %b want %b", cyc, bus16.in_ready, bus16.out_ready || !sv[S-1]); end
      ncmp++; if (bus16.out_valid !== sv[S-1]) begin nerr++; $display("FAIL rnd_out_valid cyc %0d: got %b want %b", cyc, bus16.out_valid, sv[S-1]); end
      ncmp++; if ({bus16.sum, bus16.carry, bus16.ovf} !== held) begin nerr++; $display("FAIL rnd_result cyc %0d: got %h want %h", cyc, {bus16.sum, bus16.carry, bus16.ovf}, held); end
      tick();
    end
    drive16(0, 16'h0, 16'h0, 0, 0, 1);
    for (int i = 0; i < S + 1; i++) tick();
  endtask

  task automatic test_reset_inflight();
    for (int i = 0; i < 4; i++) begin
      drive16(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 0);
      tick();
    end
    drive16(0, 16'h0, 16'h0, 0, 0, 0);
    #1;
    ncmp++; if (bus16.out_valid !== 1'b1) begin nerr++; $display("FAIL inflight_pre: got out_valid %b want 1", bus16.out_valid); end
    rst_n = 1'b0;
    #1;
    ncmp++; if (bus16.out_valid !== 1'b0 || {bus16.sum, bus16.carry, bus16.ovf} !== 18'h0) begin nerr++; $display("FAIL async_reset: got v=%b %h want 0 0", bus16.out_valid, {bus16.sum, bus16.carry, bus16.ovf}); end
    ncmp++; if (bus16.in_ready !== 1'b1) begin nerr++; $display("FAIL async_reset_in_ready: got %b want 1", bus16.in_ready); end
    model_clear();
    #4 rst_n = 1'b1;
    bus16.out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      ncmp++; if (bus16.out_valid !== 1'b0) begin nerr++; $display("FAIL stale_after_reset cyc %0d: got out_valid %b want 0", i, bus16.out_valid); end
    end
    drive16(1, 16'h1234, 16'h1111, 0, 0, 1);
    for (int c = 1; c <= S; c++) begin
      tick();
      bus16.in_valid = 0;
      ncmp++; if (bus16.out_valid !== (c == S)) begin nerr++; $display("FAIL post_reset_latency cyc %0d: got %b want %b", c, bus16.out_valid, c == S); end
    end
    ncmp++; if (bus16.sum !== 16'h2345 || bus16.carry !== 1'b0) begin nerr++; $display("FAIL post_reset_result: got %h/%b want 2345/0", bus16.sum, bus16.carry); end
    tick();
  endtask

  task automatic test_width4();
    res_t e;
    bus4.out_ready = 1; bus4.in_valid = 1; bus4.a = 4'd13; bus4.b = 4'd2; bus4.cin = 0; bus4.sub = 0;
    tick();
    ncmp++; if (bus4.out_valid !== 1'b1 || {bus4.sum, bus4.carry, bus4.ovf} !== {4'd15, 1'b0, 1'b0}) begin nerr++; $display("FAIL w4_13p2: got v=%b %0d/%b/%b want 1 15/0/0", bus4.out_valid, bus4.sum, bus4.carry, bus4.ovf); end
    bus4.a = 4'd15;
    tick();
    ncmp++; if (bus4.out_valid !== 1'b1 || {bus4.sum, bus4.carry, bus4.ovf} !== {4'd1, 1'b1, 1'b0}) begin nerr++; $display("FAIL w4_15p2: got v=%b %0d/%b/%b want 1 1/1/0", bus4.out_valid, bus4.sum, bus4.carry, bus4.ovf); end
    bus4.in_valid = 0;
    tick();
    ncmp++; if (bus4.out_valid !== 1'b0 || {bus4.sum, bus4.carry} !== {4'd1, 1'b1}) begin nerr++; $display("FAIL w4_bubble_hold: got v=%b %0d/%b want 0 1/1", bus4.out_valid, bus4.sum, bus4.carry); end
    for (int i = 0; i < 24; i++) begin
      bus4.in_valid = 1; bus4.a = 4'($urandom); bus4.b = 4'($urandom); bus4.cin = 1'($urandom); bus4.sub = 1'($urandom);
      e = ref_op(4, bus4.a, bus4.b, bus4.cin, bus4.sub);
      tick();
      ncmp++; if (bus4.out_valid !== 1'b1 || {bus4.sum, bus4.carry, bus4.ovf} !== {e.sum[3:0], e.carry, e.ovf}) begin nerr++; $display("FAIL w4_rnd[%0d]: got %h/%b/%b want %h/%b/%b", i, bus4.sum, bus4.carry, bus4.ovf, e.sum[3:0], e.carry, e.ovf); end
    end
    bus4.out_ready = 0; bus4.a = 4'd0;
    #1;
    ncmp++; if (bus4.in_ready !== 1'b0) begin nerr++; $display("FAIL w4_stall_in_ready: got %b want 0", bus4.in_ready); end
    tick();
    ncmp++; if (bus4.out_valid !== 1'b1 || {bus4.sum, bus4.carry, bus4.ovf} !== {e.sum[3:0], e.carry, e.ovf}) begin nerr++; $display("FAIL w4_stall_hold: got %h/%b/%b want %h/%b/%b", bus4.sum, bus4.carry, bus4.ovf, e.sum[3:0], e.carry, e.ovf); end
    bus4.out_ready = 1; bus4.in_valid = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    test_width4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end
endmodule
